wbs_mem_bridge: RTL
===================

WBS_MEM_BRIDGE -- requirements
Module: wbs_mem_bridge

Interface
REQ-001 The block SHALL have these parameters:
- NUM_REGIONS, default 4: number of memory regions, 1..8.
- MEM_AW, default 10: entry-address width per region.
- ENTRY_W, default 64: memory entry width, 33..64.
- RD_LAT, default 1: SRAM read latency in cycles, 1..3.
REQ-002 Ports (name, direction, width, meaning), clock and reset first:
- wb_clk_i, in, 1: the single clock.
- wb_rst_i, in, 1: reset, asynchronous, active-high.
- wbs_stb_i, in, 1: strobe.
- wbs_cyc_i, in, 1: cycle.
- wbs_we_i, in, 1: write enable.
- wbs_sel_i, in, 4: byte select (ignored).
- wbs_adr_i, in, 32: address.
- wbs_dat_i, in, 32: write data.
- wbs_ack_o, out, 1: acknowledge.
- wbs_dat_o, out, 32: read data.
- mem_csb_o, out, NUM_REGIONS: per-region chip select, active-low.
- mem_web_o, out, 1: shared write enable, active-low.
- mem_addr_o, out, MEM_AW: entry address.
- mem_wdata_o, out, ENTRY_W: entry write data.
- mem_rdata_i, in, NUM_REGIONS*ENTRY_W: region r read data at slice r.
- done_i, in, 1: algorithm done.
- busy_i, in, 1: core busy.
- start_o, out, 1: one-cycle FSM start pulse.
- mode_o, out, 2: mode register.
- debug_o, out, 1: debug register.

Function
REQ-003 Address decode SHALL work as follows:
- A request is decoded only when wbs_adr_i[31:20] == 12'h300.
- region = wbs_adr_i[19:16]; region 0 is CSR space, regions 1..NUM_REGIONS are memories.
- half = wbs_adr_i[2] (0 = bits 31:0, 1 = bits ENTRY_W-1:32).
- entry = wbs_adr_i[MEM_AW+2:3].
REQ-004 CSR map in region 0:
- 0x00 mode: RW, bits 1:0.
- 0x04 debug: RW, bit 0.
- 0x08 done: RO sticky, set by done_i; any write clears it.
- 0x0C start: WO; writing bit0=1 drives start_o high for exactly one cycle.
- 0x10 busy: RO, reflects busy_i.
- 0x14 err: RO sticky; any write clears it.
REQ-005 A request SHALL be accepted in any IDLE-state cycle with wbs_cyc_i & wbs_stb_i high; address, data and we are registered at acceptance.
REQ-006 The state machine SHALL have states IDLE, WR_ACK, RD_WAIT, RD_ACK and GAP, with these transitions:
- IDLE -> WR_ACK on an accepted write.
- IDLE -> RD_WAIT on a read that needs SRAM.
- IDLE -> RD_ACK on any other read.
- RD_WAIT -> RD_ACK after RD_LAT cycles.
- WR_ACK or RD_ACK -> GAP, asserting wbs_ack_o for that single cycle.
- GAP -> IDLE unconditionally.
REQ-007 wbs_ack_o SHALL be a one-cycle pulse. Ack latency from the acceptance edge:
- Writes and CSR/buffered reads: 1 cycle.
- SRAM reads: RD_LAT+1 cycles.
A master that holds stb/cyc high and changes the address after ack SHALL be served as a new request after GAP.
REQ-008 Memory write, lower half: the accepted write SHALL store wbs_dat_i into a 32-bit hold register; no SRAM access is made.
REQ-009 Memory write, upper half: the accepted write SHALL issue one SRAM write in the WR_ACK cycle:
- csb[region-1] = 0 and web = 0.
- mem_wdata_o = {wbs_dat_i[ENTRY_W-33:0], hold}, with upper bits truncated.
REQ-010 Memory read, lower half, or upper half that misses the capture buffer: the block SHALL issue an SRAM read (csb low, web high) in the cycle after acceptance and capture the entry on the RD_LAT-th following edge. The capture buffer SHALL record region and entry and set its valid flag.
REQ-011 Memory read, upper half hitting the capture buffer (same region and entry, valid set): the block SHALL return the captured bits ENTRY_W-1:32, zero-extended to 32 bits, with no SRAM access.
REQ-012 Any memory write to the region and entry held in the capture buffer SHALL clear its valid flag.
REQ-013 Unmapped accesses (bad prefix, region > NUM_REGIONS, or an undefined CSR offset) SHALL be acked with wbs_dat_o = 0, SHALL drop any write, and SHALL set err.
REQ-014 wbs_dat_o SHALL be valid only in the ack cycle and SHALL be 0 in all other cycles.
REQ-015 A rising done_i in the same cycle as a write to done SHALL leave done set (set wins).
REQ-016 mem_csb_o SHALL be all-ones and mem_web_o SHALL be 1 whenever no SRAM access is issued.

Reset
REQ-017 While wb_rst_i is high, the block SHALL hold these values asynchronously:
- State = IDLE.
- wbs_ack_o = 0, wbs_dat_o = 0.
- start_o = 0, mode_o = 0, debug_o = 0.
- done = 0, err = 0.
- hold = 0, capture-buffer valid flag = 0.
- mem_csb_o = all-ones, mem_web_o = 1.
REQ-018 Reset asserted mid-transaction SHALL abort the transaction with no ack, and no SRAM write SHALL occur after reset assertion.

Structure
REQ-019 A shared package wbs_bridge_pkg SHALL hold the base prefix 12'h300, the CSR offsets, and the state enum.
REQ-020 Address decoding SHALL live in one sub-module, wbs_addr_decode (combinational: region, half, entry, csr_hit, unmapped).

Verification
REQ-021 Write region 2 entry 5: lower 32'h1234_5678, then upper 32'h0000_00AB -> exactly one SRAM write, csb=4'b1101, addr=5, wdata=64'h0000_00AB_1234_5678; each ack is 1 cycle wide.
REQ-022 RD_LAT=2: read entry 5 lower then upper -> returns 32'h1234_5678 at 3 cycles from acceptance, then 32'h0000_00AB at 1 cycle with no csb activity.
REQ-023 Write 1 to 0x3000_000C -> start_o high for exactly one cycle. Pulse done_i, then read 0x3000_0008 -> 1; write it, then read again -> 0.
REQ-024 Read 0x3005_0000 with NUM_REGIONS=4 -> acked, data 0, err reads 1, no csb activity.
REQ-025 Hold stb/cyc high across 3 back-to-back reads -> 3 distinct acks, each followed by a GAP cycle.
REQ-026 Assert wb_rst_i during RD_WAIT -> no ack, all outputs at reset values, and a subsequent read works normally.

Source files
------------

// File: rtl/wbs_bridge_pkg.sv
// Shared constants for the Wishbone-to-SRAM bridge: address prefix, CSR map and FSM states.
package wbs_bridge_pkg;

  localparam logic [11:0] BASE_PREFIX = 12'h300;

  localparam logic [15:0] CSR_MODE  = 16'h0000;
  localparam logic [15:0] CSR_DEBUG = 16'h0004;
  localparam logic [15:0] CSR_DONE  = 16'h0008;
  localparam logic [15:0] CSR_START = 16'h000C;
  localparam logic [15:0] CSR_BUSY  = 16'h0010;
  localparam logic [15:0] CSR_ERR   = 16'h0014;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ACK  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_RD_ACK  = 3'd3,
    ST_GAP     = 3'd4
  } state_e;

  function automatic logic csr_defined(input logic [15:0] off);
    case (off)
      CSR_MODE, CSR_DEBUG, CSR_DONE,
      CSR_START, CSR_BUSY, CSR_ERR: csr_defined = 1'b1;
      default:                      csr_defined = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wbs_addr_decode.sv
// Combinational split of a Wishbone address into region / half / entry and
// classification as CSR hit, memory hit or unmapped.
module wbs_addr_decode
  import wbs_bridge_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int MEM_AW      = 10
) (
  input  logic [31:0]       adr,
  output logic [3:0]        region,
  output logic              half,
  output logic [MEM_AW-1:0] entry,
  output logic              csr_hit,
  output logic              mem_hit,
  output logic              unmapped
);

  logic prefix_ok_s;

  assign prefix_ok_s = (adr[31:20] == BASE_PREFIX);
  assign region      = adr[19:16];
  assign half        = adr[2];
  assign entry       = adr[MEM_AW+2:3];
  assign csr_hit     = prefix_ok_s && (region == 4'd0) && csr_defined(adr[15:0]);
  assign mem_hit     = prefix_ok_s && (region != 4'd0) && (region <= 4'(NUM_REGIONS));
  assign unmapped    = !(csr_hit || mem_hit);

endmodule

// File: rtl/wbs_mem_bridge.sv
// Wishbone slave bridging 32-bit bus accesses to wide per-region SRAMs, with a
// small CSR block and a one-entry read capture buffer for upper-half reads.
module wbs_mem_bridge
  import wbs_bridge_pkg::*;
#(
  parameter int NUM_REGIONS = 4,
  parameter int MEM_AW      = 10,
  parameter int ENTRY_W     = 64,
  parameter int RD_LAT      = 1
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic                           wbs_stb_i,
  input  logic                           wbs_cyc_i,
  input  logic                           wbs_we_i,
  input  logic [3:0]                     wbs_sel_i,
  input  logic [31:0]                    wbs_adr_i,
  input  logic [31:0]                    wbs_dat_i,
  output logic                           wbs_ack_o,
  output logic [31:0]                    wbs_dat_o,
  output logic [NUM_REGIONS-1:0]         mem_csb_o,
  output logic                           mem_web_o,
  output logic [MEM_AW-1:0]              mem_addr_o,
  output logic [ENTRY_W-1:0]             mem_wdata_o,
  input  logic [NUM_REGIONS*ENTRY_W-1:0] mem_rdata_i,
  input  logic                           done_i,
  input  logic                           busy_i,
  output logic                           start_o,
  output logic [1:0]                     mode_o,
  output logic                           debug_o
);

  localparam int UW = ENTRY_W - 32;

  state_e state_r, state_next;

  logic [3:0]        dec_region;
  logic              dec_half, dec_csr_hit, dec_mem_hit, dec_unmapped;
  logic [MEM_AW-1:0] dec_entry;

  logic                   ack_r, ack_s;
  logic [31:0]            dat_r, dat_s;
  logic [NUM_REGIONS-1:0] csb_r, csb_s, region_csb_s;
  logic                   web_r, web_s;
  logic [MEM_AW-1:0]      addr_r, addr_s;
  logic [ENTRY_W-1:0]     wdata_r, wdata_s;
  logic                   start_r, start_s;
  logic [1:0]             mode_r, mode_s;
  logic                   debug_r, debug_s, done_r, done_s, err_r, err_s;
  logic [31:0]            hold_r, hold_s, csr_rdata_s;
  logic                   cap_valid_r, cap_valid_s, cap_hit_s;
  logic [3:0]             cap_region_r, cap_region_s;
  logic [MEM_AW-1:0]      cap_entry_r, cap_entry_s;
  logic [UW-1:0]          cap_upper_r, cap_upper_s;
  logic [3:0]             req_region_r, req_region_s;
  logic                   req_half_r, req_half_s;
  logic [MEM_AW-1:0]      req_entry_r, req_entry_s;
  logic [1:0]             lat_cnt_r, lat_cnt_s;
  logic [ENTRY_W-1:0]     rdata_sel_s;
  logic                   unused_sel_s;

  assign unused_sel_s = ^wbs_sel_i;

  wbs_addr_decode #(
    .NUM_REGIONS(NUM_REGIONS),
    .MEM_AW     (MEM_AW)
  ) u_decode (
    .adr     (wbs_adr_i),
    .region  (dec_region),
    .half    (dec_half),
    .entry   (dec_entry),
    .csr_hit (dec_csr_hit),
    .mem_hit (dec_mem_hit),
    .unmapped(dec_unmapped)
  );

  assign cap_hit_s = cap_valid_r && (cap_region_r == dec_region) && (cap_entry_r == dec_entry);

  // Region one-hot (active-low) for the incoming request and read-data slice for the held request.
  always_comb begin
    region_csb_s = {NUM_REGIONS{1'b1}};
    rdata_sel_s  = {ENTRY_W{1'b0}};
    for (int r = 0; r < NUM_REGIONS; r++) begin
      region_csb_s[r] = (dec_region != 4'(r + 1));
      rdata_sel_s = rdata_sel_s | ({ENTRY_W{req_region_r == 4'(r + 1)}} & mem_rdata_i[r*ENTRY_W +: ENTRY_W]);
    end
  end

  // CSR read mux.
  always_comb begin
    case (wbs_adr_i[15:0])
      CSR_MODE:  csr_rdata_s = {30'd0, mode_r};
      CSR_DEBUG: csr_rdata_s = {31'd0, debug_r};
      CSR_DONE:  csr_rdata_s = {31'd0, done_r};
      CSR_BUSY:  csr_rdata_s = {31'd0, busy_i};
      CSR_ERR:   csr_rdata_s = {31'd0, err_r};
      default:   csr_rdata_s = 32'd0;
    endcase
  end

  // Next state and next value of every registered output.
  always_comb begin
    state_next   = state_r;
    ack_s        = 1'b0;
    dat_s        = 32'd0;
    csb_s        = {NUM_REGIONS{1'b1}};
    web_s        = 1'b1;
    addr_s       = addr_r;
    wdata_s      = wdata_r;
    start_s      = 1'b0;
    mode_s       = mode_r;
    debug_s      = debug_r;
    done_s       = done_r;
    err_s        = err_r;
    hold_s       = hold_r;
    cap_valid_s  = cap_valid_r;
    cap_region_s = cap_region_r;
    cap_entry_s  = cap_entry_r;
    cap_upper_s  = cap_upper_r;
    req_region_s = req_region_r;
    req_half_s   = req_half_r;
    req_entry_s  = req_entry_r;
    lat_cnt_s    = lat_cnt_r;

    case (state_r)
      ST_IDLE: begin
        if (wbs_cyc_i && wbs_stb_i) begin
          req_region_s = dec_region;
          req_half_s   = dec_half;
          req_entry_s  = dec_entry;
          lat_cnt_s    = 2'd0;
          if (dec_unmapped) begin
            err_s      = 1'b1;
            ack_s      = 1'b1;
            state_next = wbs_we_i ? ST_WR_ACK : ST_RD_ACK;
          end else if (wbs_we_i) begin
            ack_s      = 1'b1;
            state_next = ST_WR_ACK;
            if (dec_csr_hit) begin
              case (wbs_adr_i[15:0])
                CSR_MODE:  mode_s  = wbs_dat_i[1:0];
                CSR_DEBUG: debug_s = wbs_dat_i[0];
                CSR_DONE:  done_s  = 1'b0;
                CSR_START: start_s = wbs_dat_i[0];
                CSR_ERR:   err_s   = 1'b0;
                default:   mode_s  = mode_r;
              endcase
            end else begin
              if (cap_hit_s) begin
                cap_valid_s = 1'b0;
              end else begin
                cap_valid_s = cap_valid_r;
              end
              if (dec_half) begin
                csb_s   = region_csb_s;
                web_s   = 1'b0;
                addr_s  = dec_entry;
                wdata_s = {wbs_dat_i[ENTRY_W-33:0], hold_r};
              end else begin
                hold_s = wbs_dat_i;
              end
            end
          end else if (dec_csr_hit || (dec_half && cap_hit_s)) begin
            ack_s      = 1'b1;
            state_next = ST_RD_ACK;
            dat_s      = dec_csr_hit ? csr_rdata_s : 32'(cap_upper_r);
          end else begin
            state_next = ST_RD_WAIT;
            csb_s      = region_csb_s;
            addr_s     = dec_entry;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        if (lat_cnt_r == 2'(RD_LAT - 1)) begin
          state_next   = ST_RD_ACK;
          ack_s        = 1'b1;
          dat_s        = req_half_r ? 32'(rdata_sel_s[ENTRY_W-1:32]) : rdata_sel_s[31:0];
          cap_valid_s  = 1'b1;
          cap_region_s = req_region_r;
          cap_entry_s  = req_entry_r;
          cap_upper_s  = rdata_sel_s[ENTRY_W-1:32];
        end else begin
          lat_cnt_s = lat_cnt_r + 2'd1;
        end
      end
      ST_WR_ACK, ST_RD_ACK: state_next = ST_GAP;
      ST_GAP:               state_next = ST_IDLE;
      default:              state_next = ST_IDLE;
    endcase

    // A done_i level in the same cycle as a clearing write leaves the flag set.
    done_s = done_s | done_i;
  end

  // FSM state register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Output, CSR, hold and capture-buffer registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_r        <= 1'b0;
      dat_r        <= 32'd0;
      csb_r        <= {NUM_REGIONS{1'b1}};
      web_r        <= 1'b1;
      addr_r       <= {MEM_AW{1'b0}};
      wdata_r      <= {ENTRY_W{1'b0}};
      start_r      <= 1'b0;
      mode_r       <= 2'd0;
      debug_r      <= 1'b0;
      done_r       <= 1'b0;
      err_r        <= 1'b0;
      hold_r       <= 32'd0;
      cap_valid_r  <= 1'b0;
      cap_region_r <= 4'd0;
      cap_entry_r  <= {MEM_AW{1'b0}};
      cap_upper_r  <= {UW{1'b0}};
      req_region_r <= 4'd0;
      req_half_r   <= 1'b0;
      req_entry_r  <= {MEM_AW{1'b0}};
      lat_cnt_r    <= 2'd0;
    end else begin
      ack_r        <= ack_s;
      dat_r        <= dat_s;
      csb_r        <= csb_s;
      web_r        <= web_s;
      addr_r       <= addr_s;
      wdata_r      <= wdata_s;
      start_r      <= start_s;
      mode_r       <= mode_s;
      debug_r      <= debug_s;
      done_r       <= done_s;
      err_r        <= err_s;
      hold_r       <= hold_s;
      cap_valid_r  <= cap_valid_s;
      cap_region_r <= cap_region_s;
      cap_entry_r  <= cap_entry_s;
      cap_upper_r  <= cap_upper_s;
      req_region_r <= req_region_s;
      req_half_r   <= req_half_s;
      req_entry_r  <= req_entry_s;
      lat_cnt_r    <= lat_cnt_s;
    end
  end

  assign wbs_ack_o   = ack_r;
  assign wbs_dat_o   = dat_r;
  assign mem_csb_o   = csb_r;
  assign mem_web_o   = web_r;
  assign mem_addr_o  = addr_r;
  assign mem_wdata_o = wdata_r;
  assign start_o     = start_r;
  assign mode_o      = mode_r;
  assign debug_o     = debug_r;

endmodule
